sm4_key_expansion: RTL

//  SM4 key schedule: producer of the 32-bit round keys consumed by the round datapath.

---
 rtl/sm4_key_expansion.sv | 115 +++++++++++
 1 files changed

// File: rtl/sm4_key_expansion.sv
// sm4_key_expansion: SM4 key schedule, expands a 128-bit master key into 32 stored round keys and streams them
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   key_valid_in, key_ready_out       master key handshake (ready only in IDLE)
//   key_in, decrypt_in                master key (MK0 in [127:96]) and stream order, sampled on the key handshake
//   rk_valid_out, rk_ready_in         round key stream handshake
//   rk_out, rk_index_out, rk_last_out round key, its encryption index, final-key marker
//   busy_out                          expanding or streaming
module sm4_key_expansion #(
    parameter int NUM_ROUNDS = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_valid_in,
    output logic         key_ready_out,
    input  logic [127:0] key_in,
    input  logic         decrypt_in,
    output logic         rk_valid_out,
    input  logic         rk_ready_in,
    output logic [31:0]  rk_out,
    output logic [4:0]   rk_index_out,
    output logic         rk_last_out,
    output logic         busy_out
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [4:0] LAST     = 5'(NUM_ROUNDS - 1);
    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic [1:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [4:0]   ptr_q, ptr_d;
    logic         dec_q, dec_d;
    logic [127:0] k_q, k_d;
    logic [31:0]  rk_mem [NUM_ROUNDS];
    logic [31:0]  ck, t_in, tau, k_new;
    logic         key_hs, rk_hs;

    assign key_ready_out = state_q == S_IDLE;
    assign rk_valid_out  = state_q == S_STREAM;
    assign busy_out      = state_q != S_IDLE;
    assign rk_last_out   = rk_valid_out && ptr_q == (dec_q ? 5'd0 : LAST);
    assign rk_out        = rk_valid_out ? rk_mem[ptr_q] : '0;
    assign rk_index_out  = rk_valid_out ? ptr_q : '0;
    assign key_hs        = key_valid_in && key_ready_out;
    assign rk_hs         = rk_valid_out && rk_ready_in;

    // One key-schedule round on the window k_q = {K(i), K(i+1), K(i+2), K(i+3)}
    always_comb begin
        ck  = '0;
        tau = '0;
        // CK byte j of round i is (4i+j)*7 mod 256
        for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'({cnt_q, 2'(j)}) * 8'd7;
        t_in = k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck;
        for (int j = 0; j < 4; j++) tau[8*j +: 8] = SBOX[t_in[8*j +: 8]];
        k_new = k_q[127:96] ^ tau ^ {tau[18:0], tau[31:19]} ^ {tau[8:0], tau[31:9]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        dec_d   = dec_q;
        k_d     = k_q;
        if (key_hs) begin
            k_d     = key_in ^ FK;
            dec_d   = decrypt_in;
            cnt_d   = '0;
            state_d = S_EXPAND;
        end
        if (state_q == S_EXPAND) begin
            k_d     = {k_q[95:0], k_new};
            cnt_d   = cnt_q + 5'd1;
            state_d = cnt_q == LAST ? S_STREAM : S_EXPAND;
            ptr_d   = dec_q ? LAST : 5'd0;
        end
        if (rk_hs) begin
            // The pointer stops on the final key instead of wrapping
            ptr_d   = rk_last_out ? ptr_q : (dec_q ? ptr_q - 5'd1 : ptr_q + 5'd1);
            state_d = rk_last_out ? S_IDLE : S_STREAM;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            dec_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            dec_q   <= dec_d;
            k_q     <= k_d;
        end
    end

    // Storage only, never reset: a stream is only presented after a full expansion
    always_ff @(posedge clk) begin
        if (state_q == S_EXPAND) rk_mem[cnt_q] <= k_new;
    end
endmodule
